// File: rtl/llc_mem_responder_pkg.sv
// Shared cache types and constants for the LLC main-memory channel pair.
// Line-granular addressing: one address names one full cache line.
package llc_mem_responder_pkg;

    localparam int LINE_ADDR_BITS = 26;
    localparam int BITS_PER_LINE  = 128;

    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [BITS_PER_LINE-1:0]  line_t;

    typedef struct packed {
        logic       hwrite;
        logic [2:0] hsize;
        logic [1:0] hprot;
        line_addr_t addr;
        line_t      line;
    } llc_mem_req_t;

    typedef struct packed {
        line_t line;
    } llc_mem_rsp_t;

endpackage

// File: rtl/llc_mem_responder_mem_line_array.sv
// Single-port line store with synchronous write and registered synchronous read.
// The read register doubles as the responder's response register.
module mem_line_array #(
    parameter int LINES = 256,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(LINES)-1:0] idx_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [LINES];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the storage array deliberately has no reset so it maps onto block RAM;
    // only the read register is reset, which gives a clean zero response after reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Holds the last captured line until the next read, so data stays stable while valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/llc_mem_responder.sv
// Memory-side endpoint of the llc_mem_req / llc_mem_rsp channel pair: line store
// plus a fixed-latency, single-outstanding read responder with saturating statistics.
module llc_mem_responder
    import llc_mem_responder_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 256,
    parameter int CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                llc_mem_req_valid,
    output logic                llc_mem_req_ready,
    input  llc_mem_req_t        llc_mem_req,
    output logic                llc_mem_rsp_valid,
    input  logic                llc_mem_rsp_ready,
    output llc_mem_rsp_t        llc_mem_rsp,
    output logic                busy,
    output logic [CNT_BITS-1:0] rd_count,
    output logic [CNT_BITS-1:0] wr_count
);

    localparam int IDX_BITS = $clog2(MEM_LINES);
    localparam logic [7:0] LAT_RELOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          lat_cnt_q, lat_cnt_d;
    logic [CNT_BITS-1:0] rd_count_q, wr_count_q;
    logic                req_fire, rd_fire, wr_fire;
    line_t               rsp_line;
    logic                unused_req_bits;

    assign req_fire = llc_mem_req_valid && llc_mem_req_ready;
    assign rd_fire  = req_fire && !llc_mem_req.hwrite;
    assign wr_fire  = req_fire &&  llc_mem_req.hwrite;

    // Size/protection attributes and aliased upper address bits play no part in storage.
    assign unused_req_bits = ^{llc_mem_req.hsize, llc_mem_req.hprot,
                               llc_mem_req.addr[LINE_ADDR_BITS-1:IDX_BITS]};

    mem_line_array #(
        .LINES (MEM_LINES),
        .WIDTH (BITS_PER_LINE)
    ) u_mem_line_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (req_fire),
        .we_i    (llc_mem_req.hwrite),
        .idx_i   (llc_mem_req.addr[IDX_BITS-1:0]),
        .wdata_i (llc_mem_req.line),
        .rdata_o (rsp_line)
    );

    // NOTE: state and counters use non-blocking assignments so every register samples
    // pre-edge values; combinational blocks below use blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // NOTE: defaults at the top of the block keep every path assigned, so no latch forms.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            IDLE: begin
                if (rd_fire) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d   = WAIT;
                        lat_cnt_d = LAT_RELOAD;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == 8'd0) begin
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (llc_mem_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        llc_mem_req_ready = 1'b0;
        llc_mem_rsp_valid = 1'b0;
        busy              = 1'b1;
        case (state_q)
            IDLE: begin
                llc_mem_req_ready = 1'b1;
                busy              = 1'b0;
            end
            RESP:    llc_mem_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (rd_fire && (rd_count_q != '1)) begin
                rd_count_q <= rd_count_q + CNT_BITS'(1);
            end
            if (wr_fire && (wr_count_q != '1)) begin
                wr_count_q <= wr_count_q + CNT_BITS'(1);
            end
        end
    end

    assign llc_mem_rsp.line = rsp_line;
    assign rd_count         = rd_count_q;
    assign wr_count         = wr_count_q;

endmodule

// File: tb/tb_llc_mem_responder.sv
// Bench for llc_mem_responder: two instances (LATENCY=4/CNT_BITS=16 and LATENCY=1/CNT_BITS=2)
// checked every cycle against a timestamp-based transaction model, plus directed literals.
module tb_llc_mem_responder;
    import llc_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready, busy_v;
    llc_mem_req_t req_a, req_b;
    llc_mem_rsp_t rsp_a, rsp_b;
    logic [15:0]  rd_a, wr_a;
    logic [1:0]   rd_b, wr_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    llc_mem_responder #(.LATENCY(4), .MEM_LINES(256), .CNT_BITS(16)) dut_a (
        .clk(clk), .rst(rst),
        .llc_mem_req_valid(req_valid[0]), .llc_mem_req_ready(req_ready[0]), .llc_mem_req(req_a),
        .llc_mem_rsp_valid(rsp_valid[0]), .llc_mem_rsp_ready(rsp_ready[0]), .llc_mem_rsp(rsp_a),
        .busy(busy_v[0]), .rd_count(rd_a), .wr_count(wr_a)
    );

    llc_mem_responder #(.LATENCY(1), .MEM_LINES(256), .CNT_BITS(2)) dut_b (
        .clk(clk), .rst(rst),
        .llc_mem_req_valid(req_valid[1]), .llc_mem_req_ready(req_ready[1]), .llc_mem_req(req_b),
        .llc_mem_rsp_valid(rsp_valid[1]), .llc_mem_rsp_ready(rsp_ready[1]), .llc_mem_rsp(rsp_b),
        .busy(busy_v[1]), .rd_count(rd_b), .wr_count(wr_b)
    );

    task automatic check(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a read accepted in cycle c is pending, with valid due from cycle c+LATENCY
    // until the cycle in which the LLC takes it; nothing is accepted while one is pending.
    bit    m_pend [2];
    int    m_due  [2];
    line_t m_line [2];
    int    m_rd   [2];
    int    m_wr   [2];
    line_t m_mem  [2][256];

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int max_of(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic llc_mem_req_t req_of(input int k);
        return (k == 0) ? req_a : req_b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] <= 1'b0;
                m_line[k] <= '0;
                m_rd[k]   <= 0;
                m_wr[k]   <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_pend[k]) begin
                    if (cyc >= m_due[k] && rsp_ready[k]) m_pend[k] <= 1'b0;
                end else if (req_valid[k]) begin
                    if (req_of(k).hwrite) begin
                        m_mem[k][int'(req_of(k).addr % 256)] <= req_of(k).line;
                        if (m_wr[k] < max_of(k)) m_wr[k] <= m_wr[k] + 1;
                    end else begin
                        m_line[k] <= m_mem[k][int'(req_of(k).addr % 256)];
                        m_pend[k] <= 1'b1;
                        m_due[k]  <= cyc + lat_of(k);
                        if (m_rd[k] < max_of(k)) m_rd[k] <= m_rd[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ready_a", line_t'(req_ready[0]), line_t'(!m_pend[0]));
        check("valid_a", line_t'(rsp_valid[0]), line_t'(m_pend[0] && cyc >= m_due[0]));
        check("busy_a",  line_t'(busy_v[0]),    line_t'(m_pend[0]));
        check("line_a",  rsp_a.line,            m_line[0]);
        check("rdcnt_a", line_t'(rd_a),         line_t'(m_rd[0]));
        check("wrcnt_a", line_t'(wr_a),         line_t'(m_wr[0]));
        check("ready_b", line_t'(req_ready[1]), line_t'(!m_pend[1]));
        check("valid_b", line_t'(rsp_valid[1]), line_t'(m_pend[1] && cyc >= m_due[1]));
        check("busy_b",  line_t'(busy_v[1]),    line_t'(m_pend[1]));
        check("line_b",  rsp_b.line,            m_line[1]);
        check("rdcnt_b", line_t'(rd_b),         line_t'(m_rd[1]));
        check("wrcnt_b", line_t'(wr_b),         line_t'(m_wr[1]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic hw,
                           input line_addr_t a, input line_t l);
        llc_mem_req_t r;
        r        = '0;
        r.hwrite = hw;
        r.hsize  = 3'd5;
        r.hprot  = 2'b01;
        r.addr   = a;
        r.line   = l;
        req_valid[k] = v;
        if (k == 0) req_a = r;
        else        req_b = r;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int k, input logic hw, input line_addr_t a,
                         input line_t l, output int hs_cyc);
        bit found = 1'b0;
        hs_cyc = -1;
        set_req(k, 1'b1, hw, a, l);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                found  = 1'b1;
                hs_cyc = cyc;
                break;
            end
        end
        check("accept_timeout", line_t'(found), line_t'(1));
        @(posedge clk);
        #1;
        set_req(k, 1'b0, 1'b0, '0, '0);
    endtask

    // Returns at the falling edge of the first cycle with valid high.
    task automatic wait_valid(input int k, output int v_cyc);
        bit found = 1'b0;
        v_cyc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                found = 1'b1;
                v_cyc = cyc;
                break;
            end
        end
        check("valid_timeout", line_t'(found), line_t'(1));
    endtask

    initial begin
        int    hs, vc, hs0;
        line_t a5, l3, l4, l_old, l_new;
        a5    = {16{8'hA5}};
        l3    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        l4    = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        l_old = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
        l_new = 128'h5a5a_0f0f_c3c3_9696_5a5a_0f0f_c3c3_9696;

        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 2'b11;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready_a", line_t'(req_ready[0]), line_t'(1));
        check("rst_valid_a", line_t'(rsp_valid[0]), line_t'(0));
        check("rst_line_a",  rsp_a.line, '0);
        step();

        // Write then read in the next cycle, LATENCY=4.
        issue(0, 1'b1, 26'h12, a5, hs);
        issue(0, 1'b0, 26'h12, '0, hs);
        wait_valid(0, vc);
        check("lat4_delay", line_t'(vc - hs), line_t'(4));
        check("lat4_line",  rsp_a.line, a5);
        step();
        @(negedge clk);
        check("lat4_rdcnt", line_t'(rd_a), line_t'(1));
        check("lat4_wrcnt", line_t'(wr_a), line_t'(1));
        step();

        // LATENCY=1 read with a 10-cycle response stall and a request offered meanwhile.
        issue(1, 1'b1, 26'h33, l3, hs);
        rsp_ready[1] = 1'b0;
        issue(1, 1'b0, 26'h33, '0, hs);
        @(negedge clk);
        check("lat1_delay", line_t'(cyc - hs), line_t'(1));
        check("lat1_valid", line_t'(rsp_valid[1]), line_t'(1));
        check("lat1_ready", line_t'(req_ready[1]), line_t'(0));
        set_req(1, 1'b1, 1'b1, 26'h44, l4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", line_t'(rsp_valid[1]), line_t'(1));
            check("stall_line",  rsp_b.line, l3);
            check("stall_ready", line_t'(req_ready[1]), line_t'(0));
        end
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        rsp_ready[1] = 1'b1;
        step();
        @(negedge clk);
        check("post_hs_ready", line_t'(req_ready[1]), line_t'(1));
        check("post_hs_valid", line_t'(rsp_valid[1]), line_t'(0));
        check("stall_no_wr",   line_t'(wr_b), line_t'(1));
        step();

        // Aliasing: 0x105 and 0x005 share a line when MEM_LINES=256.
        issue(0, 1'b1, 26'h005, l_old, hs);
        issue(0, 1'b1, 26'h105, l_new, hs);
        issue(0, 1'b0, 26'h005, '0, hs);
        wait_valid(0, vc);
        check("alias_line", rsp_a.line, l_new);
        step();

        // Reset while waiting for a read.
        issue(0, 1'b0, 26'h12, '0, hs);
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", line_t'(rsp_valid[0]), line_t'(0));
        check("mid_rst_busy",  line_t'(busy_v[0]), line_t'(0));
        check("mid_rst_rdcnt", line_t'(rd_a), line_t'(0));
        check("mid_rst_wrcnt", line_t'(wr_a), line_t'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_valid", line_t'(rsp_valid[0]), line_t'(0));
        end
        step();
        issue(0, 1'b0, 26'h12, '0, hs);
        wait_valid(0, vc);
        check("after_rst_delay", line_t'(vc - hs), line_t'(4));
        check("after_rst_line",  rsp_a.line, a5);
        step();

        // Five back-to-back writes into a 2-bit counter.
        hs0 = -1;
        for (int i = 0; i < 5; i++) begin
            issue(1, 1'b1, line_addr_t'(i + 8), line_t'(i + 1), hs);
            if (i == 0) hs0 = hs;
        end
        @(negedge clk);
        check("wr_back2back", line_t'(hs - hs0), line_t'(4));
        check("wr_saturate",  line_t'(wr_b), line_t'(3));
        step();
        issue(1, 1'b0, 26'h10a, '0, hs);
        wait_valid(1, vc);
        check("sat_readback", rsp_b.line, line_t'(3));
        step();

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
